// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for a two-road traffic-light controller.
// It decodes each road's {red,yellow,green} lines into a phase, checks phase order,
// cross-road conflicts and (optionally) minimum dwell times, and latches the first fault.
// Optional feature macro: TRAFFIC_MONITOR_DWELL_CHECK_EN enables dwell counters and codes 4/5.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sample_en             lights are evaluated only on edges where this is 1
//   lights_a, lights_b    road {red, yellow, green}
//   clr                   clears fault, fault_code and fault_cnt
//   state_a, state_b      decoded phase: 0=R 1=RY 2=G 3=Y
//   change                one-cycle pulse after a sample where either road changed phase
//   fault, fault_code     sticky fault flag and code of the first latched fault
//   fault_cnt             saturating count of faulty samples
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [2:0] lights_a,
    input  logic [2:0] lights_b,
    input  logic       clr,
    output logic [1:0] state_a,
    output logic [1:0] state_b,
    output logic       change,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_cnt
);
    typedef enum logic [1:0] {PH_R, PH_RY, PH_G, PH_Y} phase_t;

    phase_t     state   [2];
    phase_t     state_d [2];
    phase_t     phase   [2];
    logic [2:0] lights  [2];
    logic [1:0] valid, legal, moved, seq_err, short_g, short_y;
    logic [2:0] code;

    assign lights[0] = lights_a;
    assign lights[1] = lights_b;
    assign state_a   = state[0];
    assign state_b   = state[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            legal[i]   = lights[i] == 3'b100 || lights[i] == 3'b110 || lights[i] == 3'b001 || lights[i] == 3'b010;
            phase[i]   = lights[i] == 3'b110 ? PH_RY : lights[i] == 3'b001 ? PH_G : lights[i] == 3'b010 ? PH_Y : PH_R;
            moved[i]   = legal[i] && phase[i] != state[i];
            // the only legal move is one step forward around R->RY->G->Y->R
            seq_err[i] = valid[i] && moved[i] && phase[i] != phase_t'(2'(state[i] + 2'd1));
            state_d[i] = sample_en && legal[i] ? phase[i] : state[i];
        end
    end

`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
    logic [CNT_W-1:0] dwell [2];
    logic [1:0]       tracked;

    // tracked marks a dwell that began after the road became valid; the first phase is never checked
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            short_g[i] = tracked[i] && moved[i] && state[i] == PH_G && dwell[i] < CNT_W'(MIN_GREEN);
            short_y[i] = tracked[i] && moved[i] && state[i] == PH_Y && dwell[i] < CNT_W'(MIN_YELLOW);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                dwell[i]   <= '0;
                tracked[i] <= 1'b0;
            end else if (sample_en && legal[i]) begin
                dwell[i]   <= !valid[i] || moved[i] ? CNT_W'(1) : &dwell[i] ? dwell[i] : dwell[i] + CNT_W'(1);
                tracked[i] <= valid[i] && (tracked[i] || moved[i]);
            end
        end
    end
`else
    assign short_g = 2'b00;
    assign short_y = 2'b00;
`endif

    // lowest code wins; conflict is only reachable when both roads decoded legally
    always_comb begin
        code = 3'd0;
        if (sample_en)
            code = ~&legal ? 3'd1 : (phase[0] != PH_R && phase[1] != PH_R) ? 3'd2 :
                   |seq_err ? 3'd3 : |short_g ? 3'd4 : |short_y ? 3'd5 : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= '{PH_R, PH_R};
            valid      <= 2'b00;
            change     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_cnt  <= 8'd0;
        end else begin
            state  <= state_d;
            change <= sample_en && |moved;
            if (sample_en)
                valid <= valid | legal;
            // a fault on the clearing edge restarts the record with this sample
            if (clr) begin
                fault      <= |code;
                fault_code <= code;
                fault_cnt  <= {7'd0, |code};
            end else if (|code) begin
                if (!fault) begin
                    fault      <= 1'b1;
                    fault_code <= code;
                end
                fault_cnt <= &fault_cnt ? fault_cnt : fault_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed and randomized checks of traffic_light_monitor
// against a phase-level reference model kept in the bench.
module tb_traffic_light_monitor;
    localparam int MIN_G = 4;
    localparam int MIN_Y = 2;
    localparam logic [2:0] ENC [4] = '{3'b100, 3'b110, 3'b001, 3'b010};

    logic       clk = 1'b0;
    logic       rst = 1'b1, sample_en = 1'b0, clr = 1'b0;
    logic [2:0] lights_a = 3'b100, lights_b = 3'b100;
    logic [1:0] state_a, state_b;
    logic       change, fault;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;

    traffic_light_monitor #(.MIN_GREEN(MIN_G), .MIN_YELLOW(MIN_Y), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .lights_a(lights_a), .lights_b(lights_b),
        .clr(clr), .state_a(state_a), .state_b(state_b), .change(change), .fault(fault),
        .fault_code(fault_code), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model: phase index per road, samples spent in the phase, and fault record
    int m_ph [2];
    int m_dw [2];
    bit m_valid [2];
    bit m_trk [2];
    int e_change, e_fault, e_code, e_cnt;

    function automatic int dec(input logic [2:0] l);
        for (int k = 0; k < 4; k++)
            if (l == ENC[k]) return k;
        return -1;
    endfunction

    task automatic model_update();
        int p [2];
        int code;
        bit mv;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = 0; m_dw[i] = 0; m_valid[i] = 0; m_trk[i] = 0;
            end
            e_change = 0; e_fault = 0; e_code = 0; e_cnt = 0;
            return;
        end
        code = 0;
        e_change = 0;
        if (sample_en) begin
            p[0] = dec(lights_a);
            p[1] = dec(lights_b);
            if (p[0] < 0 || p[1] < 0) code = 1;
            else begin
                code = 99;
                if (p[0] != 0 && p[1] != 0) code = 2;
                for (int i = 0; i < 2; i++) begin
                    if (m_valid[i] && p[i] != m_ph[i]) begin
                        if ((p[i] - m_ph[i] + 4) % 4 != 1 && code > 3) code = 3;
`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
                        if (m_trk[i] && m_ph[i] == 2 && m_dw[i] < MIN_G && code > 4) code = 4;
                        if (m_trk[i] && m_ph[i] == 3 && m_dw[i] < MIN_Y && code > 5) code = 5;
`endif
                    end
                end
                if (code == 99) code = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (p[i] >= 0) begin
                    mv = p[i] != m_ph[i];
                    if (mv) e_change = 1;
                    m_trk[i] = m_valid[i] && (m_trk[i] || mv);
                    m_dw[i]  = (!m_valid[i] || mv) ? 1 : (m_dw[i] < 255 ? m_dw[i] + 1 : 255);
                    m_ph[i]  = p[i];
                    m_valid[i] = 1;
                end
            end
        end
        if (clr) begin
            e_fault = code != 0;
            e_code  = code;
            e_cnt   = code != 0 ? 1 : 0;
        end else if (code != 0) begin
            if (e_fault == 0) begin
                e_fault = 1;
                e_code  = code;
            end
            if (e_cnt < 255) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] a, input logic [2:0] b, input logic c);
        rst = r; sample_en = s; lights_a = a; lights_b = b; clr = c;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        tests++;
        if (int'(state_a) != m_ph[0] || int'(state_b) != m_ph[1] || int'(change) != e_change ||
            int'(fault) != e_fault || int'(fault_code) != e_code || int'(fault_cnt) != e_cnt) begin
            fails++;
            $display("FAIL model cycle %0d: got sa=%0d sb=%0d chg=%0d flt=%0d code=%0d cnt=%0d, want sa=%0d sb=%0d chg=%0d flt=%0d code=%0d cnt=%0d",
                     cyc, state_a, state_b, change, fault, fault_code, fault_cnt,
                     m_ph[0], m_ph[1], e_change, e_fault, e_code, e_cnt);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    initial begin
        int nch;
        int cur [2];
        int r;
        logic [2:0] l [2];
        // reset with arbitrary lights
        step(1, 1, 3'b111, 3'b001, 0);
        step(1, 1, 3'b111, 3'b001, 0);
        chk("reset_outputs", {state_a, state_b, change, fault, fault_code, fault_cnt}, 0);
        // first sample after reset: green is accepted without a sequence fault
        step(0, 1, 3'b001, 3'b100, 0);
        chk("first_sample_fault", fault, 0);
        chk("first_sample_state", state_a, 2);
        // reset mid-operation discards history
        step(1, 1, 3'b001, 3'b100, 0);
        // legal cycle R(2) RY(1) G(5) Y(3) R with B red
        nch = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 1, k < 2 ? 3'b100 : k < 3 ? 3'b110 : k < 8 ? 3'b001 : k < 11 ? 3'b010 : 3'b100, 3'b100, 0);
            nch += change;
            if (k == 2) chk("legal_state_ry", state_a, 1);
        end
        chk("legal_change_count", nch, 4);
        chk("legal_fault", fault, 0);
        chk("legal_state_end", state_a, 0);
        // conflict A green, B yellow for 4 samples
        step(0, 1, 3'b001, 3'b010, 0);
        chk("conflict_code", fault_code, 2);
        chk("conflict_cnt1", fault_cnt, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 3'b001, 3'b010, 0);
        chk("conflict_cnt4", fault_cnt, 4);
        chk("conflict_code_held", fault_code, 2);
        // clear while not sampling, then skip yellow on A
        step(0, 0, 3'b001, 3'b010, 1);
        chk("clr_fault", fault, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 3'b001, 3'b100, 0);
        chk("green_hold_fault", fault, 0);
        step(0, 1, 3'b100, 3'b100, 0);
        chk("skip_yellow_code", fault_code, 3);
        step(0, 0, 3'b100, 3'b100, 1);
        chk("skip_clr_fault", fault, 0);
        chk("skip_clr_cnt", fault_cnt, 0);
        // short yellow: RY, G(5), Y(1), R
        step(0, 1, 3'b110, 3'b100, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 3'b001, 3'b100, 0);
        step(0, 1, 3'b010, 3'b100, 0);
        step(0, 1, 3'b100, 3'b100, 0);
`ifdef TRAFFIC_MONITOR_DWELL_CHECK_EN
        chk("short_yellow_code", fault_code, 5);
`else
        chk("short_yellow_nofault", fault, 0);
`endif
        // latch a conflict, then illegal encoding + conflict + clr on one sample
        step(0, 1, 3'b110, 3'b001, 0);
        chk("prior_fault", fault, 1);
        step(0, 1, 3'b111, 3'b001, 1);
        chk("simul_code", fault_code, 1);
        chk("simul_cnt", fault_cnt, 1);
        // randomized traffic: mostly legal progressions with glitches, clears and resets
        cur[0] = 0;
        cur[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 99);
                if (r < 65) l[i] = ENC[cur[i]];
                else if (r < 92) begin
                    cur[i] = (cur[i] + 1) % 4;
                    l[i] = ENC[cur[i]];
                end else l[i] = 3'($urandom_range(0, 7));
            end
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 80, l[0], l[1], $urandom_range(0, 99) < 3);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker that reads the two-road light outputs of the traffic-light controller and flags safety and sequencing violations. It decodes each road's red/yellow/green lines, tracks phase order and per-phase dwell time, and latches the first fault with a code. It sits beside the controller on the `uo_out` light lines and is used both as an on-chip watchdog and as a bench-side checker.

## Interface
- `MIN_GREEN`, default 4: minimum green dwell, in samples.
- `MIN_YELLOW`, default 2: minimum yellow dwell, in samples.
- `CNT_W`, default 8: dwell counter width; counters saturate at 2^CNT_W-1.
- `clk` in 1: clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_en` in 1: sample strobe; the lights are evaluated only on edges where this is 1.
- `lights_a` in 3: road A `{red, yellow, green}`.
- `lights_b` in 3: road B `{red, yellow, green}`.
- `clr` in 1: clears the latched fault state.
- `state_a`, `state_b` out 2: decoded phase, where 0=R, 1=RY, 2=G, 3=Y.
- `change` out 1: one-cycle pulse when either road changed phase on the last sample.
- `fault` out 1: sticky fault flag.
- `fault_code` out 3: code of the first latched fault.
- `fault_cnt` out 8: saturating count of faulty samples.

## Operation
- Legal encodings `{r,y,g}` are 100=R, 110=RY, 001=G and 010=Y. Any other encoding is illegal, and the stored phase is then left unchanged.
- Legal order per road is R→RY→G→Y→R. Holding the same phase is always legal.
- Each road has a valid bit, cleared by reset. The first legal sample sets it. Sequence and dwell checks run only when the valid bit is already 1.
- Fault codes, in priority order where the lowest code wins on a single sample:
  - 1: illegal encoding on either road.
  - 2: conflict, i.e. both roads decode to a non-R phase.
  - 3: sequence error, an illegal phase transition.
  - 4: green dwell below `MIN_GREEN` when leaving G.
  - 5: yellow dwell below `MIN_YELLOW` when leaving Y.
- Dwell counters, one per road:
  - Set to 1 on the sample that enters a new phase.
  - Incremented on each later sample in the same phase.
  - Saturate at the maximum value.
  - A dwell value that has not yet been tracked since the valid bit was set (the first phase) is never checked.
- Fault latching:
  - On a faulty sample while `fault`=0: `fault`←1 and `fault_code`←that sample's code.
  - If `fault` is already 1, `fault_code` holds its value.
  - `fault_cnt` increments on every faulty sample and saturates at 255.
- `clr`: on the next edge, clears `fault`, `fault_code` and `fault_cnt`.
  - If a faulty sample occurs on the same edge, the fault wins: `fault`=1, the new code is latched, and `fault_cnt`=1.
- `state_*` and the dwell counters are not affected by `clr`.

## Timing
- Single stage. The sample taken on edge N is reflected in every output after edge N, so latency is 1 cycle.
- `change` is high for exactly the cycle after a sampling edge on which either road's phase differed from its stored phase. Otherwise it is 0, including on cycles with `sample_en`=0.
- With `sample_en`=0, all state holds. `clr` still acts on those cycles.
- Reset values:
  - `state_a` = `state_b` = 0.
  - `change` = 0, `fault` = 0, `fault_code` = 0, `fault_cnt` = 0.
  - Dwell counters = 0, valid bits = 0.
- Reset asserted mid-operation discards all history on that edge. The next sample is treated as a first sample.

## Configuration
- `TRAFFIC_MONITOR_DWELL_CHECK_EN`:
  - Defined: dwell counters are present and codes 4 and 5 are generated.
  - Undefined: dwell counters are removed and codes 4 and 5 never occur. Codes 1–3 behave identically in both builds.

## Test plan
- Reset: assert `rst` for 2 cycles while driving arbitrary lights → all outputs 0, and the first sample produces no sequence fault.
- Legal cycle: A runs R(2)→RY(1)→G(5)→Y(3)→R while B holds 100 → `fault`=0 throughout; `change` pulses exactly 4 times; `state_a` follows 0,1,2,3,0.
- Conflict: A=001 and B=010 on the same sample → `fault`=1, `fault_code`=2, `fault_cnt`=1 one cycle later. Holding this for 3 more samples gives `fault_cnt`=4 with `fault_code` still 2.
- Skip yellow: A goes G→R after a valid green dwell → `fault_code`=3. Then pulse `clr` → `fault`=0 and `fault_cnt`=0.
- Short yellow (macro defined): A in Y for 1 sample then R, with `MIN_YELLOW`=2 → `fault_code`=5. With the macro undefined, the same stimulus gives `fault`=0.
- Simultaneous events: A=111 and B=001 with `clr`=1 on the same sample while a prior fault is latched → `fault_code`=1 (illegal encoding beats conflict) and `fault_cnt`=1.
